nrisc_program_loader: RTL
=========================

Name: nrisc_program_loader

Overview:
Boot-time loader sitting directly upstream of the nRisc uniciclo core and its instruction/data memories.
- Receives a framed byte stream over a valid/ready interface.
- Writes payload bytes into InstrMem or DataMem through a dedicated write port.
- Holds the core in reset until a checksum-verified START record arrives.
- Replaces hierarchical memory preloading with a synthesizable load path.

Parameters:
ADDR_W, 8, memory address width; both memories are 2**ADDR_W bytes, addresses wrap modulo 2**ADDR_W.
MAGIC, 8'hA5, record sync byte.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  reset, asynchronous, active-high.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid.
in_ready  output  1  loader can accept a byte.
reload_req  input  1  single-cycle pulse; in RUN, re-enters load mode.
imem_we  output  1  instruction memory write strobe.
dmem_we  output  1  data memory write strobe.
mem_addr  output  ADDR_W  write address (shared by both memories).
mem_wdata  output  8  write data.
cpu_reset  output  1  reset to nRisc core, active-high.
load_error  output  1  sticky error flag.
sync_err_cnt  output  8  saturating count of bytes discarded while hunting for MAGIC.

Behaviour:
- Accept = in_valid && in_ready, sampled on rising CLK.
- in_ready = 1 in every state except RUN and ERROR (combinational from state).
- No backpressure during payload.
- Reset values: state IDLE, cpu_reset=1, imem_we=dmem_we=0, mem_addr=0, mem_wdata=0, load_error=0, sync_err_cnt=0.
- RESET is asynchronous, so it takes effect mid-record: strobes drop immediately and the partial record is discarded. Memory contents already written are kept.
- Record format: MAGIC, CMD, BASE, LEN, LEN payload bytes, CSUM.
- START record format: MAGIC, CMD=8'h03, CSUM.
- CMD values: 8'h01 = instruction memory, 8'h02 = data memory, 8'h03 = START.
- Checksum rule: 8-bit sum of CMD, BASE, LEN, all payload bytes and CSUM must equal 8'h00 (MAGIC excluded).
- State machine, one byte accepted per transition:
  IDLE: byte==MAGIC -> CMD. Otherwise discard and increment sync_err_cnt, saturating at 8'hFF.
  CMD: clear running sum, add byte. 01/02 -> BASE (latch target). 03 -> CSUM. Any other value -> ERROR.
  BASE: latch address counter = byte -> LEN.
  LEN: latch remaining = byte. 0 -> CSUM, else -> DATA.
  DATA: each accepted byte is written in the following cycle.
    - Registered 1-cycle latency: imem_we or dmem_we =1 for exactly one cycle, with mem_addr = current counter and mem_wdata = byte.
    - Counter then increments, wrapping FF->00 for ADDR_W=8.
    - remaining decrements; when it reaches 0 -> CSUM.
  CSUM: add byte and check the sum.
    - Nonzero -> ERROR.
    - Zero and START -> RUN; cpu_reset falls on the clock edge that accepts CSUM.
    - Zero otherwise -> IDLE.
  RUN: cpu_reset=0, in_ready=0. reload_req=1 -> IDLE, and cpu_reset rises on that edge.
  ERROR: load_error=1, cpu_reset=1, in_ready=0. Sticky until RESET; reload_req is ignored.
- Writes performed before a bad CSUM are not rolled back. The core stays in reset, so they are harmless.
- imem_we and dmem_we are never both 1. Outside DATA-driven write cycles, both are 0.
- mem_addr and mem_wdata hold their last value when no strobe is active.

Decomposition:
- Shared package nrisc_pkg:
  - CMD_IMEM, CMD_DMEM, CMD_START constants.
  - MAGIC default.
  - Loader state enum (IDLE, CMD, BASE, LEN, DATA, CSUM, RUN, ERROR).
- One sub-module is natural: nrisc_loader_csum (8-bit running-sum accumulator with clear/add/is_zero).
- Everything else stays in the FSM module.

Test Plan:
1. Stream the data record A5 02 00 05 05 08 FF 01 0A E2 -> five dmem_we pulses at addr 0..4 with data 05,08,FF,01,0A. imem_we stays 0, cpu_reset stays 1, state returns to IDLE.
2. Stream an 11-byte instruction record at BASE 00 (payload 88 91 9D 42 A1 24 43 2C AE C3 00, correct CSUM), then START A5 03 FD -> eleven imem_we pulses. cpu_reset falls on the edge accepting FD, and in_ready=0 afterwards.
3. Send 00 13 then a valid record -> sync_err_cnt=2 and no write occurs for the discarded bytes.
4. Send A5 02 FE 03 11 22 33 with the correct CSUM -> writes at FE=11, FF=22, 00=33 (wrap-around). Send A5 01 00 00 FF (LEN=0) -> no write, back to IDLE.
5. Send a data record with the last byte as CSUM+1, and separately CMD=07 -> load_error=1, in_ready=0, cpu_reset=1; START is ignored. After RESET, load_error=0.
6. Assert RESET after 2 of 5 payload bytes -> strobes drop asynchronously, state IDLE, cpu_reset=1. Separately: in RUN, pulse reload_req -> cpu_reset=1 the next edge and in_ready=1.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc boot loader: record commands, the default
// sync byte and the loader state encoding.
package nrisc_pkg;

  localparam logic [7:0] CMD_IMEM      = 8'h01;
  localparam logic [7:0] CMD_DMEM      = 8'h02;
  localparam logic [7:0] CMD_START     = 8'h03;
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_BASE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } load_state_e;

endpackage

// File: rtl/nrisc_loader_csum.sv
// 8-bit running-sum accumulator for loader records. zero_o reports whether the
// sum would be zero once the byte currently presented on din_i is included,
// so the checksum byte can be judged on the same edge that accepts it.
module nrisc_loader_csum (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] din_i,
  output logic       zero_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic [7:0] sum_with_din;

  assign sum_with_din = sum_q + din_i;
  assign zero_o       = (sum_with_din == 8'h00);

  // Next sum: clear restarts from zero (optionally adding this byte), add accumulates.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = add_i ? din_i : 8'h00;
    end else if (add_i) begin
      sum_d = sum_with_din;
    end
  end

  // Sum register; every record clears it on its CMD byte, so no reset is needed.
  always_ff @(posedge clk_i) begin
    sum_q <= sum_d;
  end

endmodule

// File: rtl/nrisc_program_loader.sv
// Boot-time program loader for the nRisc core. Parses a framed byte stream
// (MAGIC, CMD, BASE, LEN, payload, CSUM), writes payload bytes into the
// instruction or data memory one cycle after acceptance, and keeps the core
// in reset until a checksum-verified START record has been received.
module nrisc_program_loader
  import nrisc_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload_req,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              load_error,
  output logic [7:0]        sync_err_cnt
);

  load_state_e       state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [7:0]        remain_q, remain_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        sync_cnt_q, sync_cnt_d;

  logic accept;
  logic csum_clr;
  logic csum_add;
  logic csum_zero;

  // Ready and core reset derive purely from the current state, so the edge
  // that enters or leaves RUN moves cpu_reset on that same edge.
  assign in_ready     = (state_q != ST_RUN) && (state_q != ST_ERROR);
  assign accept       = in_valid && in_ready;
  assign cpu_reset    = (state_q != ST_RUN);
  assign load_error   = (state_q == ST_ERROR);
  assign imem_we      = imem_we_q;
  assign dmem_we      = dmem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign sync_err_cnt = sync_cnt_q;

  nrisc_loader_csum u_csum (
    .clk_i  (CLK),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .din_i  (in_data),
    .zero_o (csum_zero)
  );

  // Record parser: next state, field latches and the registered write request.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_cnt_d  = addr_cnt_q;
    remain_d    = remain_q;
    imem_we_d   = 1'b0;
    dmem_we_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sync_cnt_d  = sync_cnt_q;
    csum_clr    = 1'b0;
    csum_add    = 1'b0;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == MAGIC) begin
            state_d = ST_CMD;
          end else if (sync_cnt_q != 8'hFF) begin
            sync_cnt_d = sync_cnt_q + 8'd1;
          end
        end
        ST_CMD: begin
          csum_clr = 1'b1;
          csum_add = 1'b1;
          cmd_d    = in_data;
          if ((in_data == CMD_IMEM) || (in_data == CMD_DMEM)) begin
            state_d = ST_BASE;
          end else if (in_data == CMD_START) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_BASE: begin
          csum_add   = 1'b1;
          addr_cnt_d = ADDR_W'(in_data);
          state_d    = ST_LEN;
        end
        ST_LEN: begin
          csum_add = 1'b1;
          remain_d = in_data;
          state_d  = (in_data == 8'h00) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          csum_add    = 1'b1;
          imem_we_d   = (cmd_q == CMD_IMEM);
          dmem_we_d   = (cmd_q == CMD_DMEM);
          mem_addr_d  = addr_cnt_q;
          mem_wdata_d = in_data;
          addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
          remain_d    = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (!csum_zero) begin
            state_d = ST_ERROR;
          end else if (cmd_q == CMD_START) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Reload only leaves RUN; ERROR stays put until RESET.
    if ((state_q == ST_RUN) && reload_req) begin
      state_d = ST_IDLE;
    end
  end

  // Control and write-port registers; RESET drops the strobes immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      sync_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      imem_we_q   <= imem_we_d;
      dmem_we_q   <= dmem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sync_cnt_q  <= sync_cnt_d;
    end
  end

  // Record fields; each is loaded before use within a record, so no reset.
  always_ff @(posedge CLK) begin
    cmd_q      <= cmd_d;
    addr_cnt_q <= addr_cnt_d;
    remain_q   <= remain_d;
  end

endmodule
